nihilist_stream_codec: RTL and testbench

Byte-serial Nihilist (Polybius + additive key) codec, the sequential successor to the combinational fixed-length decrypt block.
- Key is loaded serially, one character per handshake, up to P_KEY_MAX_LEN characters.
- Each message byte is then encrypted or decrypted against the repeating key, one byte per cycle, with valid/ready flow control on input and output.
- Sits between a byte-stream source (UART/FIFO) and a byte-stream sink in the crypto datapath.

---
 rtl/nihilist_stream_codec_pkg.sv | 82 ++++++++
 rtl/nihilist_stream_codec_if.sv | 41 ++++
 rtl/nihilist_stream_codec_polybius_lut.sv | 24 ++
 rtl/nihilist_stream_codec.sv | 226 ++++++++++++++++++++++
 tb/tb_nihilist_stream_codec.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/nihilist_stream_codec_pkg.sv
// ---------------------------------------------------------------------------
// nihilist_pkg
// Shared types, constants and lookup helpers for the Nihilist stream codec.
//   - state_e     : controller states (S_IDLE, S_KEY, S_RUN)
//   - lut_res_t   : {valid, value} result of a square lookup
//   - SQUARE      : 5x5 Polybius square, row-major (index = 5*(row-1)+(col-1))
//   - CODE_OF     : inverse of SQUARE, indexed by letter ('A'..'Z'), J -> I
//   - char_to_code: ASCII letter -> code 10*row+col
//   - code_to_char: code 10*row+col -> ASCII letter
// Build option: NIHILIST_CODEC_LOWER_EN folds lowercase a-z to uppercase
// before lookup; when undefined, lowercase letters are not valid characters.
// ---------------------------------------------------------------------------
package nihilist_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_KEY,
        S_RUN
    } state_e;

    typedef struct packed {
        logic       valid;
        logic [7:0] value;
    } lut_res_t;

    localparam logic [7:0] CODE_DIGIT_MIN = 8'd1;
    localparam logic [7:0] CODE_DIGIT_MAX = 8'd5;
    localparam logic [7:0] ERR_CHAR       = 8'h3F;

    // D A N I L / B C E F G / H K M O P / Q R S T U / V W X Y Z
    localparam logic [7:0] SQUARE [25] = '{
        8'h44, 8'h41, 8'h4E, 8'h49, 8'h4C,
        8'h42, 8'h43, 8'h45, 8'h46, 8'h47,
        8'h48, 8'h4B, 8'h4D, 8'h4F, 8'h50,
        8'h51, 8'h52, 8'h53, 8'h54, 8'h55,
        8'h56, 8'h57, 8'h58, 8'h59, 8'h5A
    };

    // Codes for 'A'..'Z'; J shares I's cell.
    localparam logic [7:0] CODE_OF [26] = '{
        8'd12, 8'd21, 8'd22, 8'd11, 8'd23, 8'd24, 8'd25, 8'd31, 8'd14,
        8'd14, 8'd32, 8'd15, 8'd33, 8'd13, 8'd34, 8'd35, 8'd41, 8'd42,
        8'd43, 8'd44, 8'd45, 8'd51, 8'd52, 8'd53, 8'd54, 8'd55
    };

    function automatic lut_res_t char_to_code(input logic [7:0] ch);
        lut_res_t   res;
        logic [7:0] up;
        logic [4:0] idx;
        res = '{valid: 1'b0, value: 8'h00};
        up  = ch;
`ifdef NIHILIST_CODEC_LOWER_EN
        if (ch >= 8'h61 && ch <= 8'h7A) begin
            up = ch - 8'h20;
        end
`endif
        idx = 5'(up - 8'h41);
        if (up >= 8'h41 && up <= 8'h5A) begin
            res.valid = 1'b1;
            res.value = CODE_OF[idx];
        end
        return res;
    endfunction

    function automatic lut_res_t code_to_char(input logic [7:0] code);
        lut_res_t   res;
        logic [7:0] tens;
        logic [7:0] ones;
        logic [4:0] pos;
        res  = '{valid: 1'b0, value: 8'h00};
        tens = code / 8'd10;
        ones = code % 8'd10;
        pos  = 5'((tens - CODE_DIGIT_MIN) * 8'd5 + (ones - CODE_DIGIT_MIN));
        if (tens >= CODE_DIGIT_MIN && tens <= CODE_DIGIT_MAX &&
            ones >= CODE_DIGIT_MIN && ones <= CODE_DIGIT_MAX) begin
            res.valid = 1'b1;
            res.value = SQUARE[pos];
        end
        return res;
    endfunction

endpackage

// File: rtl/nihilist_stream_codec_if.sv
// ---------------------------------------------------------------------------
// nihilist_stream_codec_if
// Handshake bundle of the Nihilist stream codec.
//   key channel : i_w_key_valid/char/last -> o_r_key_ready, o_r_key_err
//   in channel  : i_w_in_valid/data/last, i_w_mode -> o_r_in_ready
//   out channel : o_r_out_valid/data/last/err <- i_w_out_ready
//   status      : o_r_busy
// master = byte source/sink side, slave = codec.
// ---------------------------------------------------------------------------
interface nihilist_stream_codec_if;
    logic       i_w_mode;
    logic       i_w_key_valid;
    logic [7:0] i_w_key_char;
    logic       i_w_key_last;
    logic       o_r_key_ready;
    logic       o_r_key_err;
    logic       i_w_in_valid;
    logic [7:0] i_w_in_data;
    logic       i_w_in_last;
    logic       o_r_in_ready;
    logic       o_r_out_valid;
    logic [7:0] o_r_out_data;
    logic       o_r_out_last;
    logic       o_r_out_err;
    logic       i_w_out_ready;
    logic       o_r_busy;

    modport master (
        output i_w_mode, i_w_key_valid, i_w_key_char, i_w_key_last,
               i_w_in_valid, i_w_in_data, i_w_in_last, i_w_out_ready,
        input  o_r_key_ready, o_r_key_err, o_r_in_ready, o_r_out_valid,
               o_r_out_data, o_r_out_last, o_r_out_err, o_r_busy
    );

    modport slave (
        input  i_w_mode, i_w_key_valid, i_w_key_char, i_w_key_last,
               i_w_in_valid, i_w_in_data, i_w_in_last, i_w_out_ready,
        output o_r_key_ready, o_r_key_err, o_r_in_ready, o_r_out_valid,
               o_r_out_data, o_r_out_last, o_r_out_err, o_r_busy
    );
endinterface

// File: rtl/nihilist_stream_codec_polybius_lut.sv
// ---------------------------------------------------------------------------
// polybius_lut
// Combinational Polybius lookup in either direction.
//   i_dec   : 0 = ASCII letter -> code, 1 = code -> ASCII letter
//   i_value : letter or code
//   o_value : code or letter (0 when invalid)
//   o_valid : lookup succeeded
// ---------------------------------------------------------------------------
module polybius_lut
    import nihilist_pkg::*;
(
    input  logic       i_dec,
    input  logic [7:0] i_value,
    output logic [7:0] o_value,
    output logic       o_valid
);
    lut_res_t res;

    always_comb begin
        res     = i_dec ? code_to_char(i_value) : char_to_code(i_value);
        o_value = res.value;
        o_valid = res.valid;
    end
endmodule

// File: rtl/nihilist_stream_codec.sv
// ---------------------------------------------------------------------------
// nihilist_stream_codec
// Byte-serial Nihilist codec: serial key load, then per-byte encrypt
// (code + key code) or decrypt ((byte - key code) -> letter) against the
// repeating key, with valid/ready on input and a single registered output.
//   i_w_clk : clock
//   i_w_rst : synchronous active-high reset
//   bus     : nihilist_stream_codec_if.slave (key, in, out channels, busy)
// Parameters: P_KEY_MAX_LEN (max key characters), P_KIDX_W (key index width).
// Build option: NIHILIST_CODEC_LOWER_EN (lowercase accepted, see package).
// ---------------------------------------------------------------------------
module nihilist_stream_codec
    import nihilist_pkg::*;
#(
    parameter int P_KEY_MAX_LEN = 16,
    parameter int P_KIDX_W      = (P_KEY_MAX_LEN > 1) ? $clog2(P_KEY_MAX_LEN) : 1
) (
    input logic                    i_w_clk,
    input logic                    i_w_rst,
    nihilist_stream_codec_if.slave bus
);
    // key_len needs one extra bit so a full-length key is representable.
    localparam int               LEN_W   = P_KIDX_W + 1;
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(P_KEY_MAX_LEN);

    state_e                state_q, state_d;
    logic [LEN_W-1:0]      key_len_q, key_len_d;
    logic [P_KIDX_W-1:0]   kidx_q, kidx_d;
    logic                  mode_q, mode_d;
    logic                  last_seen_q, last_seen_d;
    logic                  key_err_q, key_err_d;
    logic                  out_valid_q, out_valid_d;
    logic [7:0]            out_data_q, out_data_d;
    logic                  out_last_q, out_last_d;
    logic                  out_err_q, out_err_d;

    logic [7:0]            key_mem_q [P_KEY_MAX_LEN];
    logic                  key_we;
    logic [P_KIDX_W-1:0]   key_wr_idx;

    logic                  key_ready, in_ready, key_acc, in_acc;
    logic [7:0]            key_code;
    logic                  key_char_ok;
    logic [LEN_W-1:0]      key_len_inc;
    logic                  eff_mode;
    logic [P_KIDX_W-1:0]   eff_kidx;
    logic [7:0]            k_code;
    logic [8:0]            diff;
    logic [7:0]            lut_value, lut_in;
    logic                  lut_ok;
    logic [7:0]            res_data;
    logic                  res_ok;

    function automatic logic [P_KIDX_W-1:0] next_kidx(input logic [P_KIDX_W-1:0] idx,
                                                      input logic [LEN_W-1:0]    len);
        logic [LEN_W-1:0] inc;
        inc = {1'b0, idx} + LEN_W'(1);
        return (inc >= len) ? '0 : inc[P_KIDX_W-1:0];
    endfunction

    polybius_lut u_key_lut (
        .i_dec   (1'b0),
        .i_value (bus.i_w_key_char),
        .o_value (key_code),
        .o_valid (key_char_ok)
    );

    // Handshake readiness. In S_IDLE a pending key character wins over a
    // message byte; in S_RUN the output stage frees up in the same cycle it
    // is consumed, giving full throughput.
    always_comb begin
        key_ready = (state_q != S_RUN);
        in_ready  = 1'b0;
        case (state_q)
            S_IDLE:  in_ready = (key_len_q != '0) && !bus.i_w_key_valid;
            S_RUN:   in_ready = !last_seen_q && (!out_valid_q || bus.i_w_out_ready);
            default: in_ready = 1'b0;
        endcase
    end

    assign key_acc = bus.i_w_key_valid && key_ready;
    assign in_acc  = bus.i_w_in_valid && in_ready;

    // The first byte of a message is accepted in S_IDLE, so it uses the live
    // mode input and key index 0; later bytes use the latched values.
    assign eff_mode = (state_q == S_IDLE) ? bus.i_w_mode : mode_q;
    assign eff_kidx = (state_q == S_IDLE) ? '0 : kidx_q;
    assign k_code   = key_mem_q[eff_kidx];
    assign diff     = {1'b0, bus.i_w_in_data} - {1'b0, k_code};
    assign lut_in   = eff_mode ? bus.i_w_in_data : diff[7:0];

    polybius_lut u_data_lut (
        .i_dec   (!eff_mode),
        .i_value (lut_in),
        .o_value (lut_value),
        .o_valid (lut_ok)
    );

    always_comb begin
        if (eff_mode) begin
            res_ok   = lut_ok;
            res_data = lut_ok ? lut_value + k_code : 8'h00;
        end else begin
            // A negative difference can alias to a legal code in its low byte.
            res_ok   = lut_ok && !diff[8];
            res_data = res_ok ? lut_value : ERR_CHAR;
        end
    end

    assign key_len_inc = key_len_q + LEN_W'(key_char_ok);

    // NOTE: every signal assigned here gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d     = state_q;
        key_len_d   = key_len_q;
        kidx_d      = kidx_q;
        mode_d      = mode_q;
        last_seen_d = last_seen_q;
        key_err_d   = key_err_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_err_d   = out_err_q;
        key_we      = 1'b0;
        key_wr_idx  = key_len_q[P_KIDX_W-1:0];

        if (bus.i_w_out_ready) begin
            out_valid_d = 1'b0;
        end
        if (in_acc) begin
            out_valid_d = 1'b1;
            out_data_d  = res_data;
            out_last_d  = bus.i_w_in_last;
            out_err_d   = !res_ok;
        end

        case (state_q)
            S_IDLE: begin
                if (key_acc) begin
                    // A new load restarts the key and clears the error flag.
                    key_err_d  = !key_char_ok;
                    key_len_d  = LEN_W'(key_char_ok);
                    key_we     = key_char_ok;
                    key_wr_idx = '0;
                    if (!(bus.i_w_key_last || (key_char_ok && MAX_LEN == LEN_W'(1)))) begin
                        state_d = S_KEY;
                    end
                end else if (in_acc) begin
                    state_d     = S_RUN;
                    mode_d      = bus.i_w_mode;
                    last_seen_d = bus.i_w_in_last;
                    kidx_d      = next_kidx('0, key_len_q);
                end
            end
            S_KEY: begin
                if (key_acc) begin
                    key_we    = key_char_ok;
                    key_len_d = key_len_inc;
                    if (!key_char_ok) begin
                        key_err_d = 1'b1;
                    end
                    if (bus.i_w_key_last || key_len_inc == MAX_LEN) begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_RUN: begin
                if (in_acc) begin
                    last_seen_d = bus.i_w_in_last;
                    kidx_d      = next_kidx(kidx_q, key_len_q);
                end
                if (out_valid_q && bus.i_w_out_ready && out_last_q) begin
                    state_d     = S_IDLE;
                    last_seen_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge i_w_clk) begin
        if (i_w_rst) begin
            state_q     <= S_IDLE;
            key_len_q   <= '0;
            kidx_q      <= '0;
            mode_q      <= 1'b0;
            last_seen_q <= 1'b0;
            key_err_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
            out_last_q  <= 1'b0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            key_len_q   <= key_len_d;
            kidx_q      <= kidx_d;
            mode_q      <= mode_d;
            last_seen_q <= last_seen_d;
            key_err_q   <= key_err_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_err_q   <= out_err_d;
        end
    end

    // NOTE: key storage has no reset; key_len = 0 after reset marks every
    // entry as unused, so its contents are never observed.
    always_ff @(posedge i_w_clk) begin
        if (key_we) begin
            key_mem_q[key_wr_idx] <= key_code;
        end
    end

    assign bus.o_r_key_ready = key_ready;
    assign bus.o_r_key_err   = key_err_q;
    assign bus.o_r_in_ready  = in_ready;
    assign bus.o_r_out_valid = out_valid_q;
    assign bus.o_r_out_data  = out_data_q;
    assign bus.o_r_out_last  = out_last_q;
    assign bus.o_r_out_err   = out_err_q;
    assign bus.o_r_busy      = (state_q != S_IDLE);
endmodule

// File: tb/tb_nihilist_stream_codec.sv
// ---------------------------------------------------------------------------
// tb_nihilist_stream_codec
// Directed self-checking bench for nihilist_stream_codec. Inputs change on
// the falling edge; outputs are sampled 1 ns later, mid-cycle.
// ---------------------------------------------------------------------------
module tb_nihilist_stream_codec;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [7:0] m_in  [8];
    logic [7:0] m_exp [8];
    logic       m_err [8];
    int         m_len;

    always #5 clk = ~clk;

    nihilist_stream_codec_if bus ();

    nihilist_stream_codec #(.P_KEY_MAX_LEN(16)) dut (
        .i_w_clk (clk),
        .i_w_rst (rst),
        .bus     (bus)
    );

    task automatic idle_inputs();
        bus.i_w_mode      = 1'b0;
        bus.i_w_key_valid = 1'b0;
        bus.i_w_key_char  = 8'h00;
        bus.i_w_key_last  = 1'b0;
        bus.i_w_in_valid  = 1'b0;
        bus.i_w_in_data   = 8'h00;
        bus.i_w_in_last   = 1'b0;
        bus.i_w_out_ready = 1'b1;
    endtask

    task automatic set_in_str(input string s);
        m_len = s.len();
        for (int i = 0; i < m_len; i++) m_in[i] = s[i];
    endtask

    task automatic set_in_bytes(input logic [63:0] v, input int n);
        m_len = n;
        for (int i = 0; i < n; i++) m_in[i] = v[8*(n-1-i) +: 8];
    endtask

    task automatic set_exp_bytes(input logic [63:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            m_exp[i] = v[8*(n-1-i) +: 8];
            m_err[i] = 1'b0;
        end
    endtask

    task automatic set_exp_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            m_exp[i] = s[i];
            m_err[i] = 1'b0;
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %b want %b", name, got, want);
        end
    endtask

    // Loads a key; the message channel is held valid throughout to show that
    // a key character always takes priority and message bytes stall.
    task automatic load_key(input string s, input logic exp_err);
        for (int i = 0; i < s.len(); i++) begin
            @(negedge clk);
            bus.i_w_key_valid = 1'b1;
            bus.i_w_key_char  = s[i];
            bus.i_w_key_last  = (i == s.len() - 1);
            bus.i_w_in_valid  = 1'b1;
            bus.i_w_in_data   = 8'h41;
            #1;
            check_bit({"key_ready ", s}, bus.o_r_key_ready, 1'b1);
            check_bit({"in_ready_during_key ", s}, bus.o_r_in_ready, 1'b0);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        check_bit({"busy_after_key ", s}, bus.o_r_busy, 1'b0);
        check_bit({"key_err ", s}, bus.o_r_key_err, exp_err);
    endtask

    // Streams m_in and checks every output beat against m_exp/m_err.
    // stall[c] = 1 drops out_ready in loop cycle c.
    task automatic run_msg(input string name, input logic mode,
                           input logic [15:0] stall, output int cycles);
        int i = 0;
        int j = 0;
        int cyc = 0;
        while (j < m_len && cyc < 200) begin
            @(negedge clk);
            bus.i_w_mode      = mode;
            bus.i_w_in_valid  = (i < m_len);
            bus.i_w_in_data   = (i < m_len) ? m_in[i] : 8'h00;
            bus.i_w_in_last   = (i == m_len - 1);
            bus.i_w_out_ready = (cyc < 16) ? !stall[cyc] : 1'b1;
            #1;
            if (bus.o_r_out_valid) begin
                n_cmp++;
                if (bus.o_r_out_data !== m_exp[j]) begin
                    n_bad++;
                    $display("FAIL %s[%0d] data: got %h want %h", name, j, bus.o_r_out_data, m_exp[j]);
                end
                n_cmp++;
                if (bus.o_r_out_err !== m_err[j] || bus.o_r_out_last !== (j == m_len - 1)) begin
                    n_bad++;
                    $display("FAIL %s[%0d] err/last: got %b/%b want %b/%b", name, j,
                             bus.o_r_out_err, bus.o_r_out_last, m_err[j], (j == m_len - 1));
                end
                if (!bus.i_w_out_ready) check_bit({name, " in_ready_stalled"}, bus.o_r_in_ready, 1'b0);
                if (bus.i_w_out_ready) j++;
            end
            if (i == m_len) check_bit({name, " in_ready_after_last"}, bus.o_r_in_ready, 1'b0);
            if (bus.i_w_in_valid && bus.o_r_in_ready) i++;
            cyc++;
        end
        cycles = cyc;
        if (j != m_len) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s timeout: got %0d beats want %0d", name, j, m_len);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        check_bit({name, " busy_after_msg"}, bus.o_r_busy, 1'b0);
    endtask

    task automatic check_cycles(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s cycles: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic check_reset_values(input string name);
        check_bit({name, " out_valid"}, bus.o_r_out_valid, 1'b0);
        check_bit({name, " out_last"},  bus.o_r_out_last,  1'b0);
        check_bit({name, " out_err"},   bus.o_r_out_err,   1'b0);
        check_bit({name, " key_err"},   bus.o_r_key_err,   1'b0);
        check_bit({name, " busy"},      bus.o_r_busy,      1'b0);
        check_bit({name, " key_ready"}, bus.o_r_key_ready, 1'b1);
        check_bit({name, " in_ready"},  bus.o_r_in_ready,  1'b0);
        n_cmp++;
        if (bus.o_r_out_data !== 8'h00) begin
            n_bad++;
            $display("FAIL %s out_data: got %h want 00", name, bus.o_r_out_data);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        bus.i_w_in_valid = 1'b1;
        #1;
        check_reset_values("reset");
        rst = 1'b0;
        idle_inputs();
    endtask

    task automatic test_encrypt();
        int cyc;
        load_key("DANILA", 1'b0);
        set_in_str("LLIITT");
        set_exp_bytes(64'h1A1B1B1C3B38, 6);
        run_msg("enc_lliitt", 1'b1, 16'h0000, cyc);
        check_cycles("enc_lliitt", cyc, 7);
    endtask

    task automatic test_decrypt();
        int cyc;
        set_in_bytes(64'h1A1B1B1C3B38, 6);
        set_exp_str("LLIITT");
        run_msg("dec_lliitt", 1'b0, 16'h0000, cyc);
        check_cycles("dec_lliitt", cyc, 7);
    endtask

    task automatic test_key_wrap();
        int cyc;
        set_in_str("TTTTTTTT");
        set_exp_bytes(64'h3738393A3B383738, 8);
        run_msg("enc_wrap", 1'b1, 16'h0000, cyc);
        check_cycles("enc_wrap", cyc, 9);
    endtask

    task automatic test_errors();
        int cyc;
        set_in_bytes(64'h1105, 2);
        set_exp_bytes(64'h3F3F, 2);
        m_err[0] = 1'b1;
        m_err[1] = 1'b1;
        run_msg("dec_bad", 1'b0, 16'h0000, cyc);

        set_in_str("5");
        set_exp_bytes(64'h00, 1);
        m_err[0] = 1'b1;
        run_msg("enc_digit", 1'b1, 16'h0000, cyc);

        set_in_str("l");
`ifdef NIHILIST_CODEC_LOWER_EN
        set_exp_bytes(64'h1A, 1);
`else
        set_exp_bytes(64'h00, 1);
        m_err[0] = 1'b1;
`endif
        run_msg("enc_lower", 1'b1, 16'h0000, cyc);

        // '#' is dropped: the stored key must still be DANILA.
        load_key("DA#NILA", 1'b1);
        set_in_str("LLIITT");
        set_exp_bytes(64'h1A1B1B1C3B38, 6);
        run_msg("enc_after_bad_key", 1'b1, 16'h0000, cyc);
        load_key("DANILA", 1'b0);
    endtask

    task automatic test_backpressure();
        int cyc;
        set_in_str("LLIITT");
        set_exp_bytes(64'h1A1B1B1C3B38, 6);
        run_msg("enc_stall", 1'b1, 16'b0000_0000_0001_1100, cyc);
        check_cycles("enc_stall", cyc, 10);
    endtask

    task automatic test_reset_mid();
        int i = 0;
        int cyc = 0;
        set_in_str("LLIITT");
        while (i < 3 && cyc < 50) begin
            @(negedge clk);
            bus.i_w_mode     = 1'b1;
            bus.i_w_in_valid = 1'b1;
            bus.i_w_in_data  = m_in[i];
            #1;
            if (bus.o_r_in_ready) i++;
            cyc++;
        end
        check_cycles("mid_accepted", i, 3);
        @(negedge clk);
        bus.i_w_in_data = m_in[3];
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset_values("mid_reset");
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            check_bit("stall_no_key in_ready", bus.o_r_in_ready, 1'b0);
            check_bit("stall_no_key out_valid", bus.o_r_out_valid, 1'b0);
            check_bit("stall_no_key busy", bus.o_r_busy, 1'b0);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_encrypt();
        test_decrypt();
        test_key_wrap();
        test_errors();
        test_backpressure();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
